mcpu_soc_mmio_arb: RTL



---
 rtl/mcpu_soc_mmio_arb.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mcpu_soc_mmio_arb.sv
// Two-master round-robin arbiter and access sequencer for the MMIO peripheral bus.
// One access at a time: a single-cycle issue with a write-enable pulse, optional
// wait states holding the address, read-data capture, then a one-cycle ack.
module mcpu_soc_mmio_arb #(
    parameter int ACCESS_WAIT = 0
) (
    input  logic        clkrst_core_clk,
    input  logic        clkrst_core_rst,
    input  logic        m0_req,
    input  logic [30:2] m0_addr,
    input  logic [3:0]  m0_wren,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [30:2] m1_addr,
    input  logic [3:0]  m1_wren,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [30:2] mmio_addr,
    output logic [3:0]  mmio_wren,
    output logic [31:0] mmio_wdata,
    input  logic [31:0] mmio_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(ACCESS_WAIT);

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic [30:2] addr_q, addr_d;
    logic [3:0]  wren_q, wren_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        capture;

    // Next-state, request latching, read capture and bus/ack outputs.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        addr_d     = addr_q;
        wren_d     = wren_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        capture    = 1'b0;
        mmio_addr  = '0;
        mmio_wren  = '0;
        mmio_wdata = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    // Under contention the master that did not win last time goes next.
                    gnt_d   = (m0_req && m1_req) ? ~last_q : m1_req;
                    last_d  = gnt_d;
                    addr_d  = gnt_d ? m1_addr  : m0_addr;
                    wren_d  = gnt_d ? m1_wren  : m0_wren;
                    wdata_d = gnt_d ? m1_wdata : m0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mmio_addr  = addr_q;
                mmio_wren  = wren_q;
                mmio_wdata = wdata_q;
                if (ACCESS_WAIT == 0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d   = WAIT_LD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mmio_addr  = addr_q;
                mmio_wdata = wdata_q;
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                m0_ack  = ~gnt_q;
                m1_ack  = gnt_q;
                state_d = IDLE;
            end
        endcase

        if (capture && (wren_q == 4'h0)) begin
            if (gnt_q) rdata1_d = mmio_rdata;
            else       rdata0_d = mmio_rdata;
        end
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wren_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wren_q   <= wren_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule
